// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Stall/flush/hold generator for the 5-stage pipeline.
//            Optional counters enabled by macro HAZARD_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsStore,
    input  logic             ID_BranchReg,
    input  logic             ID_BranchTaken,
    input  logic             ID_Halt,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [REG_W-1:0] IDEX_Rd,
    input  logic             EXMem_MemRead,
    input  logic [REG_W-1:0] EXMem_Rd,
    input  logic             MemWB_Halt,
    input  logic             IMem_Busy,
    input  logic             DMem_Busy,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             Pipe_Hold,
    output logic             Halted,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DWAIT   = 2'd1,
        S_HALTING = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   ret_halt_q, ret_halt_d;   // DWAIT returns to HALTING when set

    logic w_lu, w_br, w_stall, w_eff_halting;
    logic w_pc_w, w_ifid_w, w_flush, w_bubble, w_hold, w_halted;

    always_comb begin
        w_lu = IDEX_MemRead && (IDEX_Rd != '0) &&
               ((ID_UsesRs && (IDEX_Rd == IFID_Rs)) ||
                (ID_UsesRt && !ID_IsStore && (IDEX_Rd == IFID_Rt)));
        w_br = ID_BranchReg && (IFID_Rs != '0) &&
               ((IDEX_RegWrite && (IDEX_Rd == IFID_Rs)) ||
                (EXMem_MemRead && (EXMem_Rd == IFID_Rs)));
        w_stall       = w_lu || w_br;
        w_eff_halting = (state_q == S_HALTING) ||
                        ((state_q == S_DWAIT) && ret_halt_q);
    end

    always_comb begin
        w_pc_w     = 1'b0;
        w_ifid_w   = 1'b0;
        w_flush    = 1'b0;
        w_bubble   = 1'b0;
        w_hold     = 1'b0;
        w_halted   = 1'b0;
        state_d    = state_q;
        ret_halt_d = ret_halt_q;

        if (state_q == S_HALTED) begin
            w_hold   = 1'b1;
            w_halted = 1'b1;
        end else if (DMem_Busy) begin
            w_hold  = 1'b1;
            state_d = S_DWAIT;
            if (state_q != S_DWAIT) begin
                ret_halt_d = (state_q == S_HALTING);
            end
        end else if (w_eff_halting) begin
            w_ifid_w = 1'b1;
            w_flush  = 1'b1;
            state_d  = MemWB_Halt ? S_HALTED : S_HALTING;
        end else begin
            state_d = S_RUN;
            if (w_stall) begin
                w_bubble = 1'b1;
            end else if (IMem_Busy) begin
                w_ifid_w = 1'b1;
                w_flush  = 1'b1;
            end else if (ID_BranchTaken) begin
                w_pc_w   = 1'b1;
                w_ifid_w = 1'b1;
                w_flush  = 1'b1;
            end else begin
                w_pc_w   = 1'b1;
                w_ifid_w = 1'b1;
            end
            // A halt squashed by a taken branch is on the wrong path.
            if (ID_Halt && !w_stall && !ID_BranchTaken) begin
                state_d = S_HALTING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            ret_halt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_halt_q <= ret_halt_d;
        end
    end

    assign PC_Write    = !rst && w_pc_w;
    assign IFID_Write  = !rst && w_ifid_w;
    assign IFID_Flush  = !rst && w_flush;
    assign IDEX_Bubble = !rst && w_bubble;
    assign Pipe_Hold   = !rst && w_hold;
    assign Halted      = !rst && w_halted;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // PC_Write together with IFID_Flush occurs only for a taken-branch squash.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!w_pc_w && ((state_q == S_RUN) || (state_q == S_DWAIT)) &&
            (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (w_pc_w && w_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
`else
    assign Stall_Cnt = '0;
    assign Flush_Cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed self-checking bench for hazard_stall_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int REG_W = 4;
    localparam int CNT_W = 16;

    // Output vector order: {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold, Halted}
    localparam logic [5:0] O_ZERO   = 6'b000000;
    localparam logic [5:0] O_NORM   = 6'b110000;
    localparam logic [5:0] O_STALL  = 6'b000100;
    localparam logic [5:0] O_IMEM   = 6'b011000;
    localparam logic [5:0] O_SQUASH = 6'b111000;
    localparam logic [5:0] O_HOLD   = 6'b000010;
    localparam logic [5:0] O_HLTING = 6'b011000;
    localparam logic [5:0] O_HALTED = 6'b000011;

`ifdef HAZARD_PERF_CNT_EN
    localparam int EXP_STALL = 12;
    localparam int EXP_FLUSH = 2;
`else
    localparam int EXP_STALL = 0;
    localparam int EXP_FLUSH = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] IFID_Rs, IFID_Rt, IDEX_Rd, EXMem_Rd;
    logic             ID_UsesRs, ID_UsesRt, ID_IsStore, ID_BranchReg;
    logic             ID_BranchTaken, ID_Halt, IDEX_MemRead, IDEX_RegWrite;
    logic             EXMem_MemRead, MemWB_Halt, IMem_Busy, DMem_Busy;
    logic             PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold, Halted;
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;

    int total = 0;
    int bad   = 0;
    logic [5:0] sb[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsStore(ID_IsStore),
        .ID_BranchReg(ID_BranchReg), .ID_BranchTaken(ID_BranchTaken), .ID_Halt(ID_Halt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_Rd(IDEX_Rd),
        .EXMem_MemRead(EXMem_MemRead), .EXMem_Rd(EXMem_Rd), .MemWB_Halt(MemWB_Halt),
        .IMem_Busy(IMem_Busy), .DMem_Busy(DMem_Busy),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .Pipe_Hold(Pipe_Hold), .Halted(Halted),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
    );

    task automatic clr();
        IFID_Rs = '0; IFID_Rt = '0; IDEX_Rd = '0; EXMem_Rd = '0;
        ID_UsesRs = 0; ID_UsesRt = 0; ID_IsStore = 0; ID_BranchReg = 0;
        ID_BranchTaken = 0; ID_Halt = 0; IDEX_MemRead = 0; IDEX_RegWrite = 0;
        EXMem_MemRead = 0; MemWB_Halt = 0; IMem_Busy = 0; DMem_Busy = 0;
    endtask

    // Inputs are already applied; expected value queued, checked mid-cycle,
    // then the cycle is committed at the next rising edge.
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs, e;
        sb.push_back(exp);
        @(negedge clk);
        obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold, Halted};
        e = sb.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chkcnt(input string tag, input int s, input int f);
        total++;
        assert (Stall_Cnt === CNT_W'(s)) else begin
            bad++;
            $error("FAIL %s_stall: observed=%0d expected=%0d", tag, Stall_Cnt, s);
        end
        total++;
        assert (Flush_Cnt === CNT_W'(f)) else begin
            bad++;
            $error("FAIL %s_flush: observed=%0d expected=%0d", tag, Flush_Cnt, f);
        end
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        IDEX_MemRead = 1; IDEX_Rd = 4'd3; ID_UsesRs = 1; IFID_Rs = 4'd3;
        chk("reset_outs", O_ZERO);
        chkcnt("reset_cnt", 0, 0);
        rst = 1'b0;

        clr(); chk("idle", O_NORM);

        // Load-use on Rs: one bubble, then normal flow
        clr(); IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_Rd = 4'd3; ID_UsesRs = 1; IFID_Rs = 4'd3;
        chk("lu_rs", O_STALL);
        clr(); chk("lu_after", O_NORM);

        // Store data register is exempt; non-store Rt is not
        clr(); IDEX_MemRead = 1; IDEX_Rd = 4'd3; ID_UsesRs = 1; IFID_Rs = 4'd5;
        ID_UsesRt = 1; IFID_Rt = 4'd3; ID_IsStore = 1;
        chk("sw_exempt", O_NORM);
        clr(); IDEX_MemRead = 1; IDEX_Rd = 4'd3; ID_UsesRt = 1; IFID_Rt = 4'd3;
        chk("lu_rt", O_STALL);

        // Register zero never hazards
        clr(); IDEX_MemRead = 1; IDEX_RegWrite = 1; ID_UsesRs = 1; ID_BranchReg = 1;
        chk("r0_none", O_NORM);

        // Load then register branch: two stalls, then squash when taken
        clr(); IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_Rd = 4'd4;
        ID_BranchReg = 1; ID_UsesRs = 1; IFID_Rs = 4'd4;
        chk("lbr_stall1", O_STALL);
        clr(); EXMem_MemRead = 1; EXMem_Rd = 4'd4; ID_BranchReg = 1; ID_UsesRs = 1;
        IFID_Rs = 4'd4; ID_BranchTaken = 1;
        chk("lbr_stall2", O_STALL);
        clr(); ID_BranchReg = 1; ID_UsesRs = 1; IFID_Rs = 4'd4; ID_BranchTaken = 1;
        chk("lbr_squash", O_SQUASH);
        clr(); chk("lbr_after", O_NORM);

        // ALU then register branch: one stall
        clr(); IDEX_RegWrite = 1; IDEX_Rd = 4'd6; ID_BranchReg = 1; IFID_Rs = 4'd6;
        chk("abr_stall", O_STALL);
        clr(); ID_BranchReg = 1; IFID_Rs = 4'd6; ID_BranchTaken = 1;
        chk("abr_squash", O_SQUASH);

        // Instruction memory busy outranks a taken branch
        clr(); IMem_Busy = 1; chk("imem", O_IMEM);
        clr(); IMem_Busy = 1; ID_BranchTaken = 1; chk("imem_br", O_IMEM);

        // Data memory busy for three cycles over a load-use, then the bubble
        for (int i = 0; i < 3; i++) begin
            clr(); DMem_Busy = 1; IDEX_MemRead = 1; IDEX_Rd = 4'd3; ID_UsesRs = 1; IFID_Rs = 4'd3;
            chk("dmem_hold", O_HOLD);
        end
        clr(); IDEX_MemRead = 1; IDEX_Rd = 4'd3; ID_UsesRs = 1; IFID_Rs = 4'd3;
        chk("dmem_lu", O_STALL);
        clr(); chk("dmem_after", O_NORM);

        clr(); DMem_Busy = 1; IMem_Busy = 1; chk("both_busy", O_HOLD);
        clr(); chk("both_after", O_NORM);
        chkcnt("cnt_mid", EXP_STALL, EXP_FLUSH);

        // Halt must not start under a taken branch or a stall
        clr(); ID_Halt = 1; ID_BranchTaken = 1; chk("halt_wrongpath", O_SQUASH);
        clr(); chk("halt_ignored", O_NORM);
        clr(); ID_Halt = 1; IDEX_MemRead = 1; IDEX_Rd = 4'd2; ID_UsesRs = 1; IFID_Rs = 4'd2;
        chk("halt_stalled", O_STALL);
        clr(); chk("halt_stalled_after", O_NORM);

        // Halt sequence including a data-memory wait while draining
        clr(); ID_Halt = 1; chk("halt_id", O_NORM);
        clr(); chk("halting", O_HLTING);
        clr(); DMem_Busy = 1; chk("halting_dwait", O_HOLD);
        clr(); chk("halting_resume", O_HLTING);
        clr(); MemWB_Halt = 1; chk("halt_wb", O_HLTING);
        clr(); chk("halted", O_HALTED);
        clr(); DMem_Busy = 1; ID_BranchTaken = 1; chk("halted_sticky", O_HALTED);
        rst = 1'b1; clr(); chk("halted_rst", O_ZERO);
        chkcnt("cnt_rst", 0, 0);
        rst = 1'b0; clr(); chk("post_halt_run", O_NORM);

        // Reset in the middle of a data-memory wait
        clr(); DMem_Busy = 1; chk("dwait_enter", O_HOLD);
        rst = 1'b1; clr(); DMem_Busy = 1; chk("dwait_rst", O_ZERO);
        rst = 1'b0; clr(); chk("dwait_rst_after", O_NORM);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
